wl_floor_arb: RTL
=================

# wl_floor_arb

Round-robin arbiter that time-shares one word-length reduction stage (IW→OW truncation, keeping the top OW bits) among NREQ requesters in the edge-detection datapath. Each requester presents IW-bit samples with a valid/ready handshake. The block grants one requester at a time, with optional burst locking. It returns the reduced sample through a single registered output port, tagged with the requester index. It sits between the per-channel gradient/magnitude producers and the shared downstream OW-bit stage.

## Interface
- NREQ, 4: number of requesters, 2..8
- IW, 16: input sample width
- OW, 14: output sample width; IW > OW required
- BURST, 4: max consecutive transfers granted to one requester before the pointer advances, ≥1
- IDW, 2: width of out_id, = clog2(NREQ)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester sample valid
- req_data  in  NREQ*IW  packed samples; requester i at [i*IW +: IW]
- req_ready  out  NREQ  one-hot (or zero) accept strobe
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accept
- out_data  out  OW  reduced sample
- out_id  out  IDW  index of the requester that produced out_data

## Operation
- Data is unsigned. Floor mode: out_data = din[IW-1:IW-OW].
- Output register (data, id, valid) is the only data storage. Transfer from requester i occurs when req_valid[i] && req_ready[i].
- Slot free = !out_valid || out_ready.
- req_ready[g] = slot free && req_valid[g], where g is the current grant. All other req_ready bits are 0. req_ready is never asserted for a non-valid requester.
- Grant selection: g = first requester with req_valid set, searching from pointer ptr upward with wrap (ptr, ptr+1, …, NREQ-1, 0, …). Selection is combinational from the registered ptr, lock and cnt.
- Burst lock FSM:
  - IDLE: no lock; g found by the search. On transfer from g: cnt←1, lock←g, go to LOCK if BURST>1. If BURST==1: ptr←g+1 (mod NREQ), stay IDLE.
  - LOCK: g = lock while req_valid[lock]=1. On each transfer, cnt increments.
  - LOCK exit on transfer when cnt reaches BURST: ptr←lock+1 mod NREQ, go to IDLE.
  - LOCK exit when req_valid[lock] drops: go to IDLE in that same cycle, search from ptr←lock+1. There is no grant bubble.
- Stall: if slot not free, no transfer, and ptr, lock and cnt hold.
- A requester asserting valid mid-lock waits. Worst-case wait is (NREQ-1)*BURST transfers.

## Timing
- Latency: 1 cycle, from the transfer edge to out_valid/out_data/out_id visible.
- Throughput: 1 sample/cycle while out_ready=1. Full-rate back-to-back output with no bubbles.
- out_valid stays high and out_data/out_id stay stable until out_ready=1. Output register updates only on a transfer. On out_ready with no transfer, out_valid←0.
- Simultaneous out_ready and transfer: the output is overwritten in the same edge, so the register is never lost and never duplicated.
- Reset (rst=1 at any time, including mid-burst or with out_valid high):
  - out_valid=0, out_data=0, out_id=0.
  - ptr=0, cnt=0, state IDLE.
  - req_ready=0 while rst=1.
  - A pending output is discarded.
- Reset release: first grant goes to the lowest-index valid requester.

## Configuration
- WL_ARB_ROUND_EN defined: reduction is round-half-up with saturation.
  - t = din + 2^(IW-OW-1), computed in IW+1 bits.
  - If t[IW]=1, out_data = all ones. Otherwise out_data = t[IW-1:IW-OW].
  - Latency is unchanged: 1 cycle, with the adder in front of the output register.
- Not defined: pure floor (truncation); no adder is instantiated.

## Test plan
- Single requester: req 2 streams 0x0003, 0xFFFF, 0x8004 with out_ready=1. Floor build gives out_data 0x0000, 0x3FFF, 0x2001, out_id=2, each 1 cycle after its transfer, at 1/cycle.
- Fairness, BURST=4: all 4 requesters continuously valid. Grant order is 0,0,0,0,1,1,1,1,2,…,3,3,3,3,0. No grant bubbles. Each out_id matches its grant.
- Early release: req 1 drops valid after 2 transfers in LOCK, req 3 is valid. The next cycle's transfer is from 3, with no idle cycle. The next lock starts at 3.
- Backpressure: out_ready=0 for 5 cycles with out_valid high. out_data/out_id stay stable, req_ready=0, ptr and cnt are frozen. Release gives exactly one completion per accepted input, with none lost or duplicated.
- Reset mid-burst: assert rst with req 2 in LOCK, cnt=2, out_valid=1. Outputs go to 0 asynchronously. After release, with reqs 1 and 3 valid, the first grant is 1.
- WL_ARB_ROUND_EN: inputs 0x0001→0x0000, 0x0002→0x0001, 0x0005→0x0001, 0xFFFE→0x3FFF (saturated), 0x7FFE→0x2000.

Source files
------------

// File: rtl/wl_floor_arb_if.sv
// Requester/output handshake bundle for wl_floor_arb.
// master = requester/downstream side, slave = arbiter side.
interface wl_floor_arb_if #(
  parameter int NREQ = 4,
  parameter int IW   = 16,
  parameter int OW   = 14,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*IW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [OW-1:0]      out_data;
  logic [IDW-1:0]     out_id;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/wl_floor_arb.sv
// Round-robin burst-locking arbiter in front of a shared IW->OW word-length reduction.
// Define WL_ARB_ROUND_EN for round-half-up with saturation; default is floor (truncation).
module wl_floor_arb #(
  parameter int NREQ  = 4,
  parameter int IW    = 16,
  parameter int OW    = 14,
  parameter int BURST = 4,
  parameter int IDW   = 2
) (
  input  logic         clk,
  input  logic         rst,
  wl_floor_arb_if.slave bus
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]     r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_lock;
  logic [CW-1:0]  r_cnt;
  logic           r_out_valid;
  logic [OW-1:0]  r_out_data;
  logic [IDW-1:0] r_out_id;

  logic           w_lock_hold;
  logic [IDW-1:0] w_base;
  logic [IDW:0]   w_srch;
  logic [IDW-1:0] w_grant;
  logic           w_gv;
  logic           w_free;
  logic           w_xfer;
  logic [NREQ-1:0] w_ready;
  logic [IW-1:0]  w_din;
  logic [OW-1:0]  w_red;

  function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] idx);
    if (int'(idx) == NREQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Returns {hit, index} of the first valid requester at or after base, with wrap.
  function automatic logic [IDW:0] f_search(input logic [NREQ-1:0] v, input logic [IDW-1:0] base);
    logic [IDW:0] res;
    int j;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(base) + k;
      if (j >= NREQ) j = j - NREQ;
      if (v[j]) res = {1'b1, IDW'(j)};
    end
    return res;
  endfunction

  // A dropped lock searches from lock+1 in the same cycle, so no grant bubble.
  assign w_lock_hold = (r_state == S_LOCK) && bus.req_valid[r_lock];
  assign w_base      = (r_state == S_LOCK) ? f_next(r_lock) : r_ptr;
  assign w_srch      = f_search(bus.req_valid, w_base);
  assign w_grant     = w_lock_hold ? r_lock : w_srch[IDW-1:0];
  assign w_gv        = w_lock_hold | w_srch[IDW];
  assign w_free      = !r_out_valid || bus.out_ready;
  assign w_xfer      = w_free && w_gv;

  always_comb begin
    w_ready = '0;
    if (w_xfer && !rst) w_ready[w_grant] = 1'b1;
  end

  assign w_din = bus.req_data[int'(w_grant)*IW +: IW];

`ifdef WL_ARB_ROUND_EN
  localparam logic [IW:0] HALF = {{IW{1'b0}}, 1'b1} << (IW - OW - 1);
  logic [IW:0] w_sum;
  logic        w_unused_lsb;
  assign w_sum        = {1'b0, w_din} + HALF;
  assign w_red        = w_sum[IW] ? {OW{1'b1}} : w_sum[IW-1 -: OW];
  assign w_unused_lsb = ^w_sum[IW-OW-1:0];
`else
  logic w_unused_lsb;
  assign w_red        = w_din[IW-1 -: OW];
  assign w_unused_lsb = ^w_din[IW-OW-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_red;
      r_out_id    <= w_grant;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_lock  <= '0;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      if (w_lock_hold) begin
        if (r_cnt == CW'(BURST - 1)) begin
          r_state <= S_IDLE;
          r_ptr   <= f_next(r_lock);
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_lock <= w_grant;
        r_cnt  <= CW'(1);
        if (BURST == 1) begin
          r_ptr   <= f_next(w_grant);
          r_state <= S_IDLE;
        end else begin
          r_state <= S_LOCK;
        end
      end
    end else if (w_free && (r_state == S_LOCK) && !bus.req_valid[r_lock]) begin
      r_state <= S_IDLE;
      r_ptr   <= f_next(r_lock);
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;

endmodule
